iter_div_pipe: RTL

//   Parametrised radix-2 restoring iterative divider, signed/unsigned, WIDTH-bit operands.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_lzc.sv | 24 ++
 rtl/iter_div_pipe.sv | 127 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types for the iterative divider: FSM state encoding.
package div_pkg;

  localparam int DIV_STATE_W = 2;

  typedef enum logic [DIV_STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_lzc.sv
// Combinational leading-zero count; all-zero input yields WIDTH.
module div_lzc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]           a,
  output logic [$clog2(WIDTH+1)-1:0] lz
);

  localparam int CNT_W = $clog2(WIDTH+1);

  logic found;

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found) begin
        if (a[WIDTH-1-i]) found = 1'b1;
        else              lz    = lz + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/iter_div_pipe.sv
// Radix-2 restoring iterative divider, signed/unsigned, valid/ready on both sides.
// Define DIV_EARLY_OUT_EN to skip leading-zero iterations of the dividend magnitude.
module iter_div_pipe
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dz
);

  localparam int CNT_W = $clog2(WIDTH+1);

  div_state_t       state;
  logic [WIDTH-1:0] dvd, rem, dsr;
  logic [CNT_W-1:0] count;
  logic             s_sgn, s_x, s_y;

  logic             accept;
  logic [WIDTH-1:0] neg_a_in, neg_b_in, neg_a, neg_b;
  logic [WIDTH-1:0] abs_x, abs_y, init_dvd;
  logic [CNT_W-1:0] init_n;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // One pair of negators serves both operand-abs at accept and result sign fix in FIX.
  always_comb begin
    neg_a_in = (state == FIX) ? dvd : x;
    neg_b_in = (state == FIX) ? rem : y;
    neg_a    = -neg_a_in;
    neg_b    = -neg_b_in;
    abs_x    = (div_signed && x[WIDTH-1]) ? neg_a : x;
    abs_y    = (div_signed && y[WIDTH-1]) ? neg_b : y;
  end

`ifdef DIV_EARLY_OUT_EN
  logic [CNT_W-1:0] lz;

  div_lzc #(.WIDTH(WIDTH)) u_lzc (
    .a  (abs_x),
    .lz (lz)
  );

  assign init_dvd = abs_x << lz;
  assign init_n   = CNT_W'(WIDTH) - lz;
`else
  assign init_dvd = abs_x;
  assign init_n   = CNT_W'(WIDTH);
`endif

  // Quotient bits shift into the bottom of dvd as the dividend shifts out the top.
  always_comb begin
    diff   = {1'b0, rem, dvd[WIDTH-1]} - {2'b00, dsr};
    borrow = diff[WIDTH+1];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      dvd   <= '0;
      rem   <= '0;
      dsr   <= '0;
      count <= '0;
      s_sgn <= 1'b0;
      s_x   <= 1'b0;
      s_y   <= 1'b0;
      q     <= '0;
      r     <= '0;
      dz    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            s_sgn <= div_signed;
            s_x   <= x[WIDTH-1];
            s_y   <= y[WIDTH-1];
            dsr   <= abs_y;
            dvd   <= init_dvd;
            rem   <= '0;
            count <= init_n;
            if (y == '0) begin
              q     <= '1;
              r     <= x;
              dz    <= 1'b1;
              state <= DONE;
            end else if (init_n == '0) begin
              state <= FIX;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem   <= borrow ? {rem[WIDTH-2:0], dvd[WIDTH-1]} : diff[WIDTH-1:0];
          dvd   <= {dvd[WIDTH-2:0], ~borrow};
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          q     <= (s_sgn && (s_x ^ s_y)) ? neg_a : dvd;
          r     <= (s_sgn && s_x) ? neg_b : rem;
          dz    <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
